// File: rtl/tff_toggle_sched.sv
// Round-robin scheduler granting four requesters a toggle of a shared T-flip-flop bank.
// Define TFF_SCHED_GCNT_EN to add a saturating 16-bit grant counter on port gcnt.
module tff_toggle_sched #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   mask,
    output logic [3:0]           gnt,
    output logic [WIDTH-1:0]     Q,
    output logic                 busy
`ifdef TFF_SCHED_GCNT_EN
    ,
    output logic [15:0]          gcnt
`endif
);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    state_t           state, state_nxt;
    logic [1:0]       owner, owner_nxt;
    logic [1:0]       ptr, ptr_nxt;
    logic [1:0]       win;
    logic [3:0]       cnt, cnt_nxt;
    logic [3:0]       gnt_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] mask_a [4];

    // Lowest offset from start wins; the descending scan lets it overwrite later candidates.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = start;
        for (int unsigned i = 4; i > 0; i--) begin
            idx = start + 2'(i - 1);
            if (r[idx]) pick = idx;
        end
        return pick;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) mask_a[i] = mask[i*WIDTH +: WIDTH];
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        gnt_nxt   = '0;
        q_nxt     = Q;
        win       = '0;
        if (req == '0) begin
            if (state == OWNED) ptr_nxt = owner + 2'd1;
            state_nxt = IDLE;
        end else begin
            if (state == IDLE) begin
                win     = rr_pick(req, ptr);
                cnt_nxt = 4'd1;
            end else if (req[owner] && cnt < MAX_CNT) begin
                win     = owner;
                cnt_nxt = cnt + 4'd1;
            end else begin
                // Searching from owner+1 reaches the owner last, so a lone owner is re-granted.
                win     = rr_pick(req, owner + 2'd1);
                cnt_nxt = 4'd1;
            end
            state_nxt = OWNED;
            owner_nxt = win;
            gnt_nxt   = 4'b0001 << win;
            q_nxt     = Q ^ mask_a[win];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            owner <= '0;
            cnt   <= '0;
            ptr   <= '0;
            gnt   <= '0;
            Q     <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
            ptr   <= ptr_nxt;
            gnt   <= gnt_nxt;
            Q     <= q_nxt;
        end
    end

    assign busy = (state == OWNED);

`ifdef TFF_SCHED_GCNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gcnt <= '0;
        end else if (|gnt_nxt && gcnt != 16'hFFFF) begin
            gcnt <= gcnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tff_toggle_sched.sv
// Directed bench for tff_toggle_sched with a behavioural arbitration model feeding a scoreboard.
`timescale 1ns/1ps
module tb_tff_toggle_sched;

    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [3:0]           req;
    logic [4*WIDTH-1:0]   mask;
    logic [3:0]           gnt;
    logic [WIDTH-1:0]     Q;
    logic                 busy;
`ifdef TFF_SCHED_GCNT_EN
    logic [15:0]          gcnt;
`endif

    tff_toggle_sched #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .mask (mask),
        .gnt  (gnt),
        .Q    (Q),
        .busy (busy)
`ifdef TFF_SCHED_GCNT_EN
        ,
        .gcnt (gcnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       gnt;
        logic [WIDTH-1:0] q;
        logic             busy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    bit               m_owned;
    int               m_owner, m_cnt, m_ptr;
    logic [WIDTH-1:0] m_q;
    logic [3:0]       m_gnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int first_from(input logic [3:0] r, input int s);
        for (int k = 0; k < 4; k++) begin
            if (r[(s + k) % 4]) return (s + k) % 4;
        end
        return s;
    endfunction

    task automatic model_reset();
        m_owned = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_q = '0; m_gnt = '0;
    endtask

    task automatic model(input logic [3:0] r, input logic [4*WIDTH-1:0] m);
        int w;
        if (r == 4'b0000) begin
            if (m_owned) m_ptr = (m_owner + 1) % 4;
            m_owned = 0;
            m_gnt   = '0;
            return;
        end
        if (!m_owned) begin
            w = first_from(r, m_ptr); m_cnt = 1;
        end else if (r[m_owner] && m_cnt < MAX_BURST) begin
            w = m_owner; m_cnt++;
        end else if (r[m_owner] && (r & ~(4'b0001 << m_owner)) != 4'b0000) begin
            w = first_from(r, (m_owner + 1) % 4); m_cnt = 1;
        end else if (r[m_owner]) begin
            w = m_owner; m_cnt = 1;
        end else begin
            w = first_from(r, (m_owner + 1) % 4); m_cnt = 1;
        end
        m_owned = 1;
        m_owner = w;
        m_gnt   = 4'b0001 << w;
        m_q     = m_q ^ m[w*WIDTH +: WIDTH];
    endtask

    task automatic step(input string tag, input logic [3:0] r,
                        input logic [WIDTH-1:0] m0, input logic [WIDTH-1:0] m1,
                        input logic [WIDTH-1:0] m2, input logic [WIDTH-1:0] m3);
        exp_t e;
        @(negedge clk);
        req  = r;
        mask = {m3, m2, m1, m0};
        model(r, {m3, m2, m1, m0});
        e.gnt = m_gnt; e.q = m_q; e.busy = m_owned;
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        check({tag, " gnt"},  32'(gnt),  32'(e.gnt));
        check({tag, " Q"},    32'(Q),    32'(e.q));
        check({tag, " busy"}, 32'(busy), 32'(e.busy));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        req   = '0;
        @(posedge clk); #1;
        check({tag, " rst gnt"},  32'(gnt),  32'h0);
        check({tag, " rst Q"},    32'(Q),    32'h0);
        check({tag, " rst busy"}, 32'(busy), 32'h0);
        model_reset();
        #1 reset = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        req   = '0;
        mask  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init gnt",  32'(gnt),  32'h0);
        check("init Q",    32'(Q),    32'h0);
        check("init busy", 32'(busy), 32'h0);
        @(negedge clk) reset = 1'b1;

        // single grant then idle
        step("single", 4'b0001, 8'hA5, 8'h00, 8'h00, 8'h00);
        check("single gnt const", 32'(gnt), 32'h1);
        check("single Q const",   32'(Q),   32'hA5);
        step("idle", 4'b0000, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        check("idle Q hold",  32'(Q),    32'hA5);
        check("idle busy",    32'(busy), 32'h0);

        // ptr advanced to 1 on leaving OWNED: 1001 picks requester 3
        step("ptr adv", 4'b1001, 8'h00, 8'h00, 8'h00, 8'h0F);
        check("ptr adv gnt const", 32'(gnt), 32'h8);
        step("idle2", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);

        // zero mask still consumes a grant
        step("zmask", 4'b0010, 8'hFF, 8'h00, 8'hFF, 8'hFF);
        check("zmask Q const", 32'(Q), 32'hAA);
        step("idle3", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);

        // all requesters, burst rotation
        do_reset("rr");
        for (int k = 0; k < 20; k++) begin
            step("rr", 4'b1111, 8'h01, 8'h01, 8'h01, 8'h01);
            check("rr gnt const", 32'(gnt),  32'(4'b0001 << ((k / 4) % 4)));
            check("rr Q0 const",  32'(Q[0]), 32'((k + 1) % 2));
        end
        step("idle4", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);

        // lone requester never gaps across the burst limit
        for (int k = 0; k < 10; k++) begin
            step("lone", 4'b0100, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            check("lone gnt const", 32'(gnt), 32'h4);
        end
        step("idle5", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);

        // owner drops mid-burst, search continues from owner+1
        step("drop a", 4'b0010, 8'h11, 8'h22, 8'h33, 8'h44);
        step("drop b", 4'b0010, 8'h11, 8'h22, 8'h33, 8'h44);
        step("drop c", 4'b1001, 8'h11, 8'h22, 8'h33, 8'h44);
        check("drop c gnt const", 32'(gnt), 32'h8);
        step("drop d", 4'b1001, 8'h11, 8'h22, 8'h33, 8'h44);
        check("drop d gnt const", 32'(gnt), 32'h8);
        step("drop e", 4'b0001, 8'h11, 8'h22, 8'h33, 8'h44);
        check("drop e gnt const", 32'(gnt), 32'h1);
        step("idle6", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);

        // asynchronous reset mid-burst
        do_reset("pre");
        step("burst a", 4'b0001, 8'h3C, 8'h00, 8'h00, 8'h00);
        step("burst b", 4'b0001, 8'h00, 8'h00, 8'h00, 8'h00);
        check("burst Q const", 32'(Q), 32'h3C);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async gnt",  32'(gnt),  32'h0);
        check("async Q",    32'(Q),    32'h0);
        check("async busy", 32'(busy), 32'h0);
        model_reset();
        @(posedge clk); #1;
        check("held gnt", 32'(gnt), 32'h0);
        check("held Q",   32'(Q),   32'h0);
        #1 reset = 1'b1;
        step("release", 4'b0010, 8'h00, 8'h5A, 8'h00, 8'h00);
        check("release gnt const", 32'(gnt), 32'h2);

        // random traffic against the model
        for (int k = 0; k < 40; k++) begin
            step("rand", 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
                 8'($urandom), 8'($urandom));
        end

`ifdef TFF_SCHED_GCNT_EN
        do_reset("gcnt");
        @(negedge clk);
        req  = 4'b0001;
        mask = '0;
        repeat (70000) @(posedge clk);
        #1;
        check("gcnt sat", 32'(gcnt), 32'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        check("gcnt hold", 32'(gcnt), 32'hFFFF);
        reset = 1'b0;
        #1;
        check("gcnt clr", 32'(gcnt), 32'h0);
        req = '0;
        model_reset();
        @(negedge clk) reset = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tff_toggle_sched.md
TFF_TOGGLE_SCHED -- requirements
Module: tff_toggle_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the width of the shared toggle register.
REQ-002 The block SHALL have parameter MAX_BURST, default 4, range 1..15, setting the maximum back-to-back grants one requester may take while others wait.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-005 The block SHALL have port req, input, 4 bits: req[i]=1 means requester i wants one toggle operation.
REQ-006 The block SHALL have port mask, input, 4*WIDTH bits: mask[i*WIDTH +: WIDTH] is requester i's toggle mask (T inputs).
REQ-007 The block SHALL have port gnt, output, 4 bits: one-hot registered grant, high for the cycle in which that requester's toggle is visible on Q.
REQ-008 The block SHALL have port Q, output, WIDTH bits: shared T-flip-flop bank state.
REQ-009 The block SHALL have port busy, output, 1 bit: 1 when the FSM is in OWNED.

Function
REQ-010 The FSM SHALL have two states: IDLE (no owner) and OWNED (owner index, burst count cnt 1..MAX_BURST).
REQ-011 At most one requester SHALL be granted per cycle, and gnt SHALL be zero or one-hot.
REQ-012 On the edge where requester w wins, Q SHALL update to Q XOR mask[w], gnt SHALL become onehot(w), and there SHALL be no other latency.
REQ-013 An all-zero mask SHALL still consume a grant, leaving Q unchanged.
REQ-014 In IDLE, the winner SHALL be the first set req bit searching round-robin from pointer ptr (ptr, ptr+1, ... mod 4); the FSM then goes to OWNED with owner=w, cnt=1.
REQ-015 In OWNED, if req[owner]=1 and cnt<MAX_BURST, the owner SHALL be granted again and cnt incremented.
REQ-016 In OWNED, if req[owner]=1, cnt=MAX_BURST and any other req is set, the winner SHALL be the first set bit searched from owner+1, with cnt=1.
REQ-017 In OWNED, if req[owner]=1, cnt=MAX_BURST and no other req is set, the owner SHALL be granted with cnt=1.
REQ-018 In OWNED, if req[owner]=0 and some req is set, the winner SHALL be searched from owner+1, with cnt=1.
REQ-019 With req=0, the FSM SHALL go to (or remain in) IDLE, gnt SHALL be 0, Q SHALL hold, and ptr SHALL be set to owner+1 mod 4 on leaving OWNED.
REQ-020 ptr and owner SHALL wrap 3 -> 0.
REQ-021 mask is sampled only at the granting edge, and requesters SHALL NOT be required to hold mask otherwise.
REQ-022 A req that falls in the same cycle it would have won SHALL NOT be granted (purely sampled behaviour).

Reset
REQ-023 When reset=0, regardless of clk, the block SHALL force Q=0, gnt=0, busy=0, state=IDLE, ptr=0, owner=0, cnt=0.
REQ-024 A reset asserted mid-burst SHALL abort the burst, and no grant or toggle SHALL occur until the first rising edge after reset releases.
REQ-025 On release, the first grant SHALL follow REQ-014 with ptr=0.

Configuration
REQ-026 With macro TFF_SCHED_GCNT_EN defined, the block SHALL add output gcnt, 16 bits, counting grants issued, saturating at 16'hFFFF and cleared by reset.
REQ-027 Without TFF_SCHED_GCNT_EN, no gcnt port or counter SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-028 The bench SHALL cover: WIDTH=8, reset release, req=4'b0001, mask0=8'hA5 for 1 cycle -> next cycle gnt=0001, Q=8'hA5; then req=0 -> gnt=0, Q holds 8'hA5, busy=0.
REQ-029 The bench SHALL cover: req=4'b1111 held, all masks 8'h01, MAX_BURST=4 -> gnt sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001...; Q toggles bit0 every cycle.
REQ-030 The bench SHALL cover: req=4'b0100 only, held 10 cycles -> gnt=0100 every cycle (cnt wraps to 1 after 4), with no gap.
REQ-031 The bench SHALL cover: requester 1 in burst (cnt=2), req[1] drops, req[3] and req[0] set -> requester 3 is granted next, then requester 0 after requester 3 releases.
REQ-032 The bench SHALL cover: reset driven low between clock edges during a burst with Q=8'h3C -> Q=0, gnt=0 immediately; after release with req=4'b0010 -> gnt=0010 on the first edge.
REQ-033 The bench SHALL cover, with TFF_SCHED_GCNT_EN: 70000 consecutive grants -> gcnt=16'hFFFF and holds; reset -> gcnt=0.
